// File: rtl/tone_decoder.sv
// Buzzer-line receiver: measures the half-period of a square wave, matches it
// against the five player tones and shows note, lock status and note count on a 4-digit 7-seg.
`timescale 1ns/1ps
module tone_decoder #(
  parameter int TOL         = 64,
  parameter int LOCK_CNT    = 4,
  parameter int SILENCE_CYC = 20000,
  parameter int SCAN_BIT    = 16
) (
  input  logic       clk,
  input  logic       rb,
  input  logic       tone_in,
  output logic [2:0] note,
  output logic       note_valid,
  output logic       note_evt,
  output logic [7:0] segs,
  output logic [3:0] bits
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);
  localparam logic signed [17:0] TOL_S = 18'(TOL);
  localparam logic signed [17:0] TONE [5] = '{18'sd8450, 18'sd7595, 18'sd7160, 18'sd6375, 18'sd5680};

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} fsm_t;

  // Whole acquisition state in one struct so checkers can bind to it directly.
  typedef struct packed {
    fsm_t          st;
    logic [2:0]    cand;
    logic [MW-1:0] match;
  } acq_t;

  acq_t acq_q, acq_d;

  logic [2:0]          sync_q;
  logic                edge_det;
  logic [16:0]         hp_cnt;
  logic                silence;
  logic [2:0]          cls;
  logic [MW-1:0]       m_nxt;
  logic                enter_lock, leave_lock;
  logic [7:0]          note_count;
  logic [SCAN_BIT+1:0] scan_ctr;
  logic [1:0]          sel;
  logic [7:0]          seg_d;
  logic [3:0]          bits_d;

  // sync_q[0..1] synchronize; sync_q[2] holds the previous synced level.
  always_ff @(posedge clk or posedge rb) begin
    if (rb) sync_q <= 3'b111;
    else    sync_q <= {sync_q[1:0], tone_in};
  end
  assign edge_det = sync_q[2] ^ sync_q[1];

  always_ff @(posedge clk or posedge rb) begin
    if (rb)                 hp_cnt <= '0;
    else if (edge_det)      hp_cnt <= 17'd1;
    else if (hp_cnt != '1)  hp_cnt <= hp_cnt + 17'd1;
  end
  assign silence = !edge_det && (hp_cnt == 17'(SILENCE_CYC));

  // Iterate downwards so the lowest matching tone index is the one kept.
  function automatic logic [2:0] classify(input logic [16:0] m);
    logic signed [17:0] d;
    classify = 3'd0;
    for (int k = 4; k >= 0; k--) begin
      d = $signed({1'b0, m}) - TONE[k];
      if (d <= TOL_S && d >= -TOL_S) classify = 3'(k + 1);
    end
  endfunction

  // hp_cnt on an edge cycle is exactly the half-period just completed.
  assign cls = classify(hp_cnt);

  always_ff @(posedge clk or posedge rb) begin
    if (rb) acq_q <= '{st: S_IDLE, cand: 3'd0, match: '0};
    else    acq_q <= acq_d;
  end

  always_comb begin
    acq_d      = acq_q;
    m_nxt      = '0;
    enter_lock = 1'b0;
    leave_lock = 1'b0;
    if (edge_det) begin
      unique case (acq_q.st)
        S_IDLE: acq_d = '{st: S_ACQ, cand: 3'd0, match: '0};
        S_ACQ: begin
          if (cls != 3'd0) begin
            if (cls == acq_q.cand) m_nxt = acq_q.match + 1'b1;
            else                   m_nxt = MW'(1);
            acq_d.cand  = cls;
            acq_d.match = m_nxt;
            if (m_nxt == LOCK_M) begin
              acq_d.st   = S_LOCK;
              enter_lock = 1'b1;
            end
          end else begin
            acq_d.cand  = 3'd0;
            acq_d.match = '0;
          end
        end
        default: begin
          if (cls != acq_q.cand) begin
            acq_d      = '{st: S_ACQ, cand: cls, match: MW'(cls != 3'd0)};
            leave_lock = 1'b1;
          end
        end
      endcase
    end else if (silence) begin
      acq_d      = '{st: S_IDLE, cand: 3'd0, match: '0};
      leave_lock = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rb) begin
    if (rb) begin
      note       <= 3'd0;
      note_valid <= 1'b0;
      note_evt   <= 1'b0;
      note_count <= 8'd0;
    end else begin
      note_evt <= enter_lock;
      if (enter_lock) begin
        note       <= acq_d.cand;
        note_valid <= 1'b1;
        note_count <= note_count + 8'd1;
      end else if (leave_lock) begin
        note       <= 3'd0;
        note_valid <= 1'b0;
      end
    end
  end

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'h03;  4'h1: hex7 = 8'h9F;  4'h2: hex7 = 8'h25;  4'h3: hex7 = 8'h0D;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h49;  4'h6: hex7 = 8'h41;  4'h7: hex7 = 8'h1F;
      4'h8: hex7 = 8'h01;  4'h9: hex7 = 8'h09;  4'hA: hex7 = 8'h11;  4'hB: hex7 = 8'hC1;
      4'hC: hex7 = 8'h63;  4'hD: hex7 = 8'h85;  4'hE: hex7 = 8'h61;  default: hex7 = 8'h71;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rb) begin
    if (rb) scan_ctr <= '0;
    else    scan_ctr <= scan_ctr + 1'b1;
  end
  assign sel = scan_ctr[SCAN_BIT+1:SCAN_BIT];

  always_comb begin
    seg_d  = 8'hFF;
    bits_d = 4'hF;
    unique case (sel)
      2'd0: begin
        bits_d = 4'b0111;
        seg_d  = (note == 3'd0) ? 8'hFD : hex7({1'b0, note});
      end
      2'd1: begin
        bits_d = 4'b1011;
        seg_d  = note_valid ? 8'hE3 : 8'hFF;
      end
      2'd2: begin
        bits_d = 4'b1101;
        seg_d  = hex7(note_count[7:4]);
      end
      default: begin
        bits_d = 4'b1110;
        seg_d  = hex7(note_count[3:0]);
      end
    endcase
  end

  always_ff @(posedge clk or posedge rb) begin
    if (rb) begin
      segs <= 8'hFF;
      bits <= 4'hF;
    end else begin
      segs <= seg_d;
      bits <= bits_d;
    end
  end
endmodule

// File: tb/tb_tone_decoder.sv
// Directed bench for tone_decoder: a default-parameter instance runs the lock/relock/silence
// sequences while a LOCK_CNT=1 instance sweeps a table of half-periods around the tolerance edges.
`timescale 1ns/1ps
module tb_tone_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rb, tone_in, note_valid, note_evt;
  logic [2:0] note;
  logic [7:0] segs;
  logic [3:0] bits;

  logic       rb_b, tone_b, valid_b, evt_b;
  logic [2:0] note_b;
  logic [7:0] segs_b;
  logic [3:0] bits_b;

  tone_decoder #(.SCAN_BIT(2)) dut (
    .clk(clk), .rb(rb), .tone_in(tone_in), .note(note), .note_valid(note_valid),
    .note_evt(note_evt), .segs(segs), .bits(bits)
  );

  tone_decoder #(.LOCK_CNT(1), .SCAN_BIT(2)) dut_b (
    .clk(clk), .rb(rb_b), .tone_in(tone_b), .note(note_b), .note_valid(valid_b),
    .note_evt(evt_b), .segs(segs_b), .bits(bits_b)
  );

  typedef struct {
    int unsigned p;
    logic [2:0]  exp_note;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   since  = 0;
  bit   b_done = 1'b0;
  logic [7:0] disp_exp [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    since++;
  endtask

  // Called at a negedge; locks onto the digit-0 slot and checks one full 16-cycle scan.
  task automatic check_display(input string tag);
    logic [3:0] prev;
    logic [3:0] pat [4];
    bit found;
    pat   = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    found = 1'b0;
    prev  = bits;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      @(negedge clk);
      if (bits == 4'b0111 && prev != 4'b0111) found = 1'b1;
      else prev = bits;
    end
    chk({tag, " scan start"}, 32'(found), 32'd1);
    if (found) begin
      for (int i = 0; i < 16; i++) begin
        if (i > 0) begin
          step();
          @(negedge clk);
        end
        chk({tag, " bits"}, 32'(bits), 32'(pat[i/4]));
        chk({tag, " segs"}, 32'(segs), 32'(disp_exp[i/4]));
      end
    end
  endtask

  // Toggle tone_in p clocks after the previous toggle, then check the outputs
  // just before and just after the registered decision.
  task automatic tone_edge(input int p, input logic exp_before, input logic exp_valid,
                           input logic [2:0] exp_note, input logic exp_evt, input string tag);
    while (since < p) step();
    #1 tone_in = ~tone_in;
    since = 0;
    step();
    step();
    @(negedge clk);
    chk({tag, " valid before"}, 32'(note_valid), 32'(exp_before));
    step();
    @(negedge clk);
    chk({tag, " valid"}, 32'(note_valid), 32'(exp_valid));
    chk({tag, " note"}, 32'(note), 32'(exp_note));
    chk({tag, " evt"}, 32'(note_evt), 32'(exp_evt));
    step();
    @(negedge clk);
    chk({tag, " evt after"}, 32'(note_evt), 32'd0);
  endtask

  // Main sequence on the default-parameter instance.
  initial begin
    rb      = 1'b1;
    tone_in = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1 tone_in = ~tone_in;
    end
    @(negedge clk);
    chk("reset segs", 32'(segs), 32'hFF);
    chk("reset bits", 32'(bits), 32'hF);
    chk("reset note", 32'(note), 32'd0);
    chk("reset valid", 32'(note_valid), 32'd0);
    chk("reset evt", 32'(note_evt), 32'd0);
    tone_in = 1'b1;
    @(posedge clk);
    #1 rb = 1'b0;
    since = 0;
    @(negedge clk);
    disp_exp = '{8'hFD, 8'hFF, 8'h03, 8'h03};
    check_display("idle disp");

    tone_edge(1, 1'b0, 1'b0, 3'd0, 1'b0, "t2 first");
    for (int i = 0; i < 3; i++) tone_edge(7595, 1'b0, 1'b0, 3'd0, 1'b0, "t2 acq");
    tone_edge(7595, 1'b0, 1'b1, 3'd2, 1'b1, "t2 lock");
    disp_exp = '{8'h25, 8'hE3, 8'h03, 8'h9F};
    check_display("lock2 disp");

    tone_edge(5680, 1'b1, 1'b0, 3'd0, 1'b0, "t4 drop");
    for (int i = 0; i < 2; i++) tone_edge(5680, 1'b0, 1'b0, 3'd0, 1'b0, "t4 acq");
    tone_edge(5680, 1'b0, 1'b1, 3'd5, 1'b1, "t4 relock");
    disp_exp = '{8'h49, 8'hE3, 8'h03, 8'h25};
    check_display("lock5 disp");

    // hp_cnt reaches SILENCE_CYC 20002 clocks after the last toggle.
    while (since < 20002) step();
    @(negedge clk);
    chk("t5 valid pre-silence", 32'(note_valid), 32'd1);
    chk("t5 note pre-silence", 32'(note), 32'd5);
    step();
    @(negedge clk);
    chk("t5 valid silence", 32'(note_valid), 32'd0);
    chk("t5 note silence", 32'(note), 32'd0);
    disp_exp = '{8'hFD, 8'hFF, 8'h03, 8'h25};
    check_display("silence disp");
    tone_edge(1, 1'b0, 1'b0, 3'd0, 1'b0, "t5 restart");
    tone_edge(5680, 1'b0, 1'b0, 3'd0, 1'b0, "t5 acq");

    for (int i = 0; i < 100000 && !b_done; i++) @(posedge clk);
    chk("dut_b sweep done", 32'(b_done), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Table sweep on the LOCK_CNT=1 instance: one classified half-period per vector.
  initial begin
    vec_t vecs [9];
    vecs[0] = '{7650, 3'd2};
    vecs[1] = '{7700, 3'd0};
    vecs[2] = '{8514, 3'd1};
    vecs[3] = '{8515, 3'd0};
    vecs[4] = '{7531, 3'd2};
    vecs[5] = '{7160, 3'd3};
    vecs[6] = '{6311, 3'd4};
    vecs[7] = '{5745, 3'd0};
    vecs[8] = '{5744, 3'd5};
    rb_b   = 1'b1;
    tone_b = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rb_b   = 1'b1;
      tone_b = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d reset note", i), 32'(note_b), 32'd0);
      chk($sformatf("vec%0d reset segs", i), 32'(segs_b), 32'hFF);
      @(posedge clk);
      #1 rb_b = 1'b0;
      repeat (3) @(posedge clk);
      #1 tone_b = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d first edge valid", i), 32'(valid_b), 32'd0);
      repeat (vecs[i].p - 3) @(posedge clk);
      #1 tone_b = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d note", i), 32'(note_b), 32'(vecs[i].exp_note));
      chk($sformatf("vec%0d valid", i), 32'(valid_b), 32'(vecs[i].exp_note != 3'd0));
      chk($sformatf("vec%0d evt", i), 32'(evt_b), 32'(vecs[i].exp_note != 3'd0));
    end
    // Still locked on note 5: reset must clear outputs without waiting for a clock.
    @(posedge clk);
    #2 rb_b = 1'b1;
    #1;
    chk("midlock rst note", 32'(note_b), 32'd0);
    chk("midlock rst valid", 32'(valid_b), 32'd0);
    chk("midlock rst segs", 32'(segs_b), 32'hFF);
    chk("midlock rst bits", 32'(bits_b), 32'hF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("midlock rst evt", 32'(evt_b), 32'd0);
    b_done = 1'b1;
  end
endmodule
